universal_ring_counter: RTL and testbench
=========================================

# universal_ring_counter

Parametrised circular shift register and counter. Supports ring, Johnson and serial-shift modes in either direction, with parallel load. A reference-pattern tracker flags each return to the loaded pattern and counts steps since it. This is the next-generation replacement for the fixed 5-bit ring/Johnson register in the switch/LED lab datapath and is reusable for sequencers and LED chasers of any width.

## Interface
- WIDTH, 5: register width; legal range 2..32.
- RESET_VALUE, {{(WIDTH-1){1'b0}},1'b1}: value of dout and of the reference pattern after reset.
- CW (localparam), $clog2(2*WIDTH+1): width of step_cnt.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  step enable; one shift per cycle while high.
- load  in  1  parallel load strobe.
- load_data  in  WIDTH  value loaded when load=1.
- mode  in  2  00 ring, 01 Johnson, 10 serial shift, 11 hold.
- dir  in  1  0 = shift toward MSB, 1 = shift toward LSB.
- ser_in  in  1  serial input bit for mode 10.
- dout  out  WIDTH  register contents (registered).
- wrap  out  1  one-cycle pulse when a step returns dout to the reference pattern.
- step_cnt  out  CW  steps since last reference capture or wrap; saturating.

## Operation
- Internal state: dout, ref (WIDTH), step_cnt, wrap, mode_q (registered previous mode).
- Step functions, dir=0: ring {d[W-2:0],d[W-1]}; Johnson {d[W-2:0],~d[W-1]}; serial {d[W-2:0],ser_in}.
- Step functions, dir=1: ring {d[0],d[W-1:1]}; Johnson {~d[0],d[W-1:1]}; serial {ser_in,d[W-1:1]}.
- Priority per posedge, highest first:
  - load=1: dout←load_data, ref←load_data, step_cnt←0, wrap←0, mode_q←mode. en is ignored.
  - mode≠mode_q: mode-change cycle. No shift; ref←dout; step_cnt←0; wrap←0; mode_q←mode.
  - en=1 and mode≠11: dout←step(dout). If step(dout)==ref, wrap←1 and step_cnt←0. Otherwise wrap←0 and step_cnt←step_cnt+1, saturating at 2^CW−1.
  - Otherwise (en=0 or mode=11): hold dout, ref and step_cnt; wrap←0.
- A change of dir does not recapture ref and does not clear step_cnt.
- Guaranteed periods from any start value: ring divides WIDTH; Johnson divides 2*WIDTH. Serial mode has no period guarantee; wrap fires only on an actual match.
- An all-zero or all-one value in ring mode is a fixed point. It wraps on every step (period 1); this is legal and not corrected.

## Timing
- Reset (asynchronous, immediate): dout=RESET_VALUE, ref=RESET_VALUE, step_cnt=0, wrap=0, mode_q=00.
- If mode≠00 at the first clock after reset release, that cycle is a mode-change cycle with no shift.
- Latency: input sampled at edge N; dout, wrap and step_cnt reflect it after edge N (one cycle).
- wrap is coincident with the dout value that equals ref.
- load and en together: load wins; the step is lost.
- load together with a mode change: load wins and also updates mode_q, so no extra idle cycle follows.
- rst asserted mid-sequence clears everything within the same cycle, independent of clk. Release is synchronous to the next posedge.

## Test plan
- Reset, WIDTH=5: assert rst between edges → dout=00001, wrap=0, step_cnt=0 before the next edge. Then mode=00, dir=0, en=1 for 5 cycles → dout 00010, 00100, 01000, 10000, 00001; step_cnt 1,2,3,4,0; wrap=1 only on the 5th.
- Johnson: load 00000, then mode=01, dir=0, en=1 (first cycle is a mode change, no shift; ref=00000) → dout 00001, 00011, 00111, 01111, 11111, 11110, 11100, 11000, 10000, 00000; wrap on the 10th step only.
- Ring with dir=1: load 10010 → 01001, 10100, 01010, 00101, 10010; wrap on the 5th. Toggling dir mid-sequence does not clear step_cnt.
- Serial saturation: mode=10, ser_in=1, load 00000 then 20 steps → dout 11111 from the 5th step onward; no wrap; step_cnt stops at 15.
- Priority: load=1 with en=1 and load_data=10101 → dout=10101, step_cnt=0, no shift. Changing mode while en=1 → dout unchanged for one cycle and step_cnt=0.
- Async reset mid-run: assert rst at step 3 of the Johnson sequence → dout=00001 immediately. After release, the step count restarts from 0.

Source files
------------

// File: rtl/universal_ring_counter.sv
// Parametrised ring / Johnson / serial-shift register with parallel load.
// Tracks a reference pattern, pulses wrap on each return to it and counts steps since.
module universal_ring_counter #(
  parameter int              WIDTH       = 5,
  parameter logic [WIDTH-1:0] RESET_VALUE = {{(WIDTH-1){1'b0}}, 1'b1},
  localparam int             CW          = $clog2(2*WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             ser_in,
  output logic [WIDTH-1:0] dout,
  output logic             wrap,
  output logic [CW-1:0]    step_cnt
);

  localparam logic [1:0]    MODE_HOLD = 2'b11;
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic [1:0]       mode_q, mode_d;
  logic             fill;
  logic [WIDTH-1:0] step_val;

  // Bit shifted in at the vacated end: rotated bit, its inverse, or the serial input.
  always_comb begin
    fill = ser_in;
    case (mode)
      2'b00:   fill = dir ? dout_q[0] : dout_q[WIDTH-1];
      2'b01:   fill = dir ? ~dout_q[0] : ~dout_q[WIDTH-1];
      default: fill = ser_in;
    endcase
    step_val = dir ? {fill, dout_q[WIDTH-1:1]} : {dout_q[WIDTH-2:0], fill};
  end

  always_comb begin
    dout_d = dout_q;
    ref_d  = ref_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    mode_d = mode_q;
    if (load) begin
      dout_d = load_data;
      ref_d  = load_data;
      cnt_d  = '0;
      mode_d = mode;
    end else if (mode != mode_q) begin
      // Mode change: no shift, the current value becomes the new reference.
      ref_d  = dout_q;
      cnt_d  = '0;
      mode_d = mode;
    end else if (en && (mode != MODE_HOLD)) begin
      dout_d = step_val;
      if (step_val == ref_q) begin
        wrap_d = 1'b1;
        cnt_d  = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= RESET_VALUE;
      ref_q  <= RESET_VALUE;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      mode_q <= 2'b00;
    end else begin
      dout_q <= dout_d;
      ref_q  <= ref_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      mode_q <= mode_d;
    end
  end

  assign dout     = dout_q;
  assign wrap     = wrap_q;
  assign step_cnt = cnt_q;

endmodule

// File: tb/tb_universal_ring_counter.sv
// Bench for universal_ring_counter (WIDTH=5): directed sequences plus a
// randomized run against a behavioural model of the shift/wrap/count rules.
module tb_universal_ring_counter;
  localparam int W  = 5;
  localparam int CW = $clog2(2*W+1);
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int MASK = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  load_data = '0;
  logic [1:0]    mode = 2'b00;
  logic          dir = 1'b0;
  logic          ser_in = 1'b0;
  logic [W-1:0]  dout;
  logic          wrap;
  logic [CW-1:0] step_cnt;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  // Reference model state
  int       m_dout, m_ref, m_cnt, m_mode;
  bit       m_wrap;

  universal_ring_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_data(load_data),
    .mode(mode), .dir(dir), .ser_in(ser_in),
    .dout(dout), .wrap(wrap), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  function automatic int model_next(int d, int md, bit dr, bit si);
    int msb, lsb, f;
    msb = (d >> (W-1)) & 1;
    lsb = d & 1;
    if (md == 0)      f = dr ? lsb : msb;
    else if (md == 1) f = dr ? 1 - lsb : 1 - msb;
    else              f = si;
    if (!dr) return ((d * 2) + f) & MASK;
    else     return (d / 2) + f * (1 << (W-1));
  endfunction

  task automatic model_reset();
    m_dout = 1; m_ref = 1; m_cnt = 0; m_wrap = 0; m_mode = 0;
  endtask

  task automatic model_apply();
    int nx;
    if (load) begin
      m_dout = load_data; m_ref = load_data; m_cnt = 0; m_wrap = 0; m_mode = mode;
    end else if (int'(mode) != m_mode) begin
      m_ref = m_dout; m_cnt = 0; m_wrap = 0; m_mode = mode;
    end else if (en && mode != 2'b11) begin
      nx = model_next(m_dout, mode, dir, ser_in);
      m_dout = nx;
      if (nx == m_ref) begin m_wrap = 1; m_cnt = 0; end
      else begin m_wrap = 0; if (m_cnt < CNT_MAX) m_cnt++; end
    end else begin
      m_wrap = 0;
    end
  endtask

  // Advance model and DUT one edge; outputs are sampled 1 time unit later.
  task automatic tick();
    model_apply();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int ed[5] = '{2, 4, 8, 16, 1};
    int ec[5] = '{1, 2, 3, 4, 0};
    load = 0; en = 0; mode = 2'b00; dir = 0;
    tick();
    #2 rst = 1;
    #1;
    checks++; if (dout !== 5'b00001) begin errors++; $display("FAIL reset_dout got %b want 00001", dout); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap); end
    checks++; if (step_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", step_cnt); end
    #2 rst = 0;
    model_reset();
    en = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (dout !== W'(ed[i]) || step_cnt !== CW'(ec[i]) || wrap !== (i == 4))
        begin errors++; $display("FAIL reset_ring step %0d got %b/%0d/%b want %b/%0d/%b",
          i+1, dout, step_cnt, wrap, W'(ed[i]), ec[i], i == 4); end
    end
  endtask

  task automatic test_johnson();
    int ed[10] = '{1, 3, 7, 15, 31, 30, 28, 24, 16, 0};
    load = 1; load_data = '0; mode = 2'b00; en = 0;
    tick();
    load = 0; mode = 2'b01; en = 1; dir = 0;
    tick();
    checks++; if (dout !== '0 || step_cnt !== '0 || wrap !== 1'b0)
      begin errors++; $display("FAIL johnson_modechg got %b/%0d/%b want 00000/0/0", dout, step_cnt, wrap); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (dout !== W'(ed[i]) || wrap !== (i == 9) || step_cnt !== CW'((i == 9) ? 0 : i + 1))
        begin errors++; $display("FAIL johnson step %0d got %b/%0d/%b want %b/%0d/%b",
          i+1, dout, step_cnt, wrap, W'(ed[i]), (i == 9) ? 0 : i + 1, i == 9); end
    end
  endtask

  task automatic test_ring_dir1();
    logic [W-1:0] e;
    load = 1; load_data = 5'b10010; mode = 2'b00; en = 1; dir = 1;
    tick();
    load = 0;
    exp_q = '{5'b01001, 5'b10100, 5'b01010, 5'b00101, 5'b10010};
    for (int i = 0; i < 5; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++; if (dout !== e || wrap !== (i == 4))
        begin errors++; $display("FAIL ring_dir1 step %0d got %b/%b want %b/%b", i+1, dout, wrap, e, i == 4); end
    end
    tick(); tick();
    dir = 0;
    tick();
    checks++; if (step_cnt !== CW'(3) || dout !== 5'b01001)
      begin errors++; $display("FAIL dir_toggle got %b/%0d want 01001/3", dout, step_cnt); end
  endtask

  task automatic test_serial_sat();
    int k;
    load = 1; load_data = '0; mode = 2'b10; ser_in = 1; en = 1; dir = 0;
    tick();
    load = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      k = (i >= W) ? MASK : (1 << i) - 1;
      checks++; if (dout !== W'(k) || wrap !== 1'b0 || step_cnt !== CW'((i > CNT_MAX) ? CNT_MAX : i))
        begin errors++; $display("FAIL serial step %0d got %b/%0d/%b want %b/%0d/0",
          i, dout, step_cnt, wrap, W'(k), (i > CNT_MAX) ? CNT_MAX : i); end
    end
  endtask

  task automatic test_priority();
    load = 1; en = 1; load_data = 5'b10101; mode = 2'b10;
    tick();
    checks++; if (dout !== 5'b10101 || step_cnt !== '0 || wrap !== 1'b0)
      begin errors++; $display("FAIL load_prio got %b/%0d/%b want 10101/0/0", dout, step_cnt, wrap); end
    load = 0; mode = 2'b00;
    tick();
    checks++; if (dout !== 5'b10101 || step_cnt !== '0)
      begin errors++; $display("FAIL mode_chg got %b/%0d want 10101/0", dout, step_cnt); end
    tick();
    checks++; if (dout !== 5'b01011 || step_cnt !== CW'(1))
      begin errors++; $display("FAIL after_mode_chg got %b/%0d want 01011/1", dout, step_cnt); end
  endtask

  task automatic test_async_reset();
    load = 1; load_data = '0; mode = 2'b00; en = 0; dir = 0;
    tick();
    load = 0; mode = 2'b01; en = 1;
    tick(); tick(); tick(); tick();
    checks++; if (dout !== 5'b00111)
      begin errors++; $display("FAIL johnson_pre_rst got %b want 00111", dout); end
    #2 rst = 1;
    #1;
    checks++; if (dout !== 5'b00001 || step_cnt !== '0 || wrap !== 1'b0)
      begin errors++; $display("FAIL async_rst got %b/%0d/%b want 00001/0/0", dout, step_cnt, wrap); end
    #2 rst = 0;
    model_reset();
    tick();
    checks++; if (dout !== 5'b00001 || step_cnt !== '0)
      begin errors++; $display("FAIL rst_modechg got %b/%0d want 00001/0", dout, step_cnt); end
    tick();
    checks++; if (dout !== 5'b00011 || step_cnt !== CW'(1))
      begin errors++; $display("FAIL rst_restart got %b/%0d want 00011/1", dout, step_cnt); end
  endtask

  task automatic test_random();
    load = 1; load_data = W'($urandom); mode = 2'b00; en = 0;
    tick();
    for (int i = 0; i < 400; i++) begin
      load      = ($urandom_range(0, 15) == 0);
      load_data = W'($urandom);
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      en        = ($urandom_range(0, 4) != 0);
      ser_in    = 1'($urandom);
      tick();
      checks++; if (dout !== W'(m_dout) || wrap !== m_wrap || step_cnt !== CW'(m_cnt))
        begin errors++; $display("FAIL random cyc %0d got %b/%b/%0d want %b/%b/%0d",
          i, dout, wrap, step_cnt, W'(m_dout), m_wrap, m_cnt); end
    end
  endtask

  initial begin
    rst = 1;
    model_reset();
    #12 rst = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_johnson();
    test_ring_dir1();
    test_serial_sat();
    test_priority();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
